dcache_wb_unit: RTL
===================

Name: dcache_wb_unit

Overview:
Writeback (victim/probe) engine of the L1 data cache; the outbound counterpart of the refill path. Accepts one dirty-block writeback request, reads the block row by row from the data array and streams it as a TileLink channel-C burst (ReleaseData or ProbeAckData). For voluntary releases it holds the slot until ReleaseAck returns. Sits between the MSHR/probe arbiter and the channel-C arbiter.

Parameters:
paddrBits, 32, physical address width
blockBytes, 64, cache block size in bytes; blockOffBits = log2(blockBytes) = 6
nSets, 64, sets; idxBits = log2(nSets) = 6
nWays, 8, ways; way select is one-hot
rowBits, 128, data-array row width = channel-C beat width
tagBits, 20, paddrBits - 12 (page-untag bits)
sourceBits, 3, TileLink source id width
refillCycles, 4, beats per block = blockBytes*8/rowBits (derived)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  writeback request
req_ready  out  1  high only in IDLE
req_tag  in  tagBits  victim tag
req_idx  in  idxBits  set index
req_way_en  in  nWays  one-hot victim way
req_voluntary  in  1  1 = ReleaseData, 0 = ProbeAckData
req_param  in  3  TileLink shrink/report param
req_source  in  sourceBits  source id
data_req_valid  out  1  data-array read request
data_req_ready  in  1  data-array arbiter grant
data_req_addr  out  idxBits+2  {idx, row}
data_req_way_en  out  nWays  way select
data_resp  in  rowBits  read data, valid exactly 1 cycle after an accepted read
c_valid  out  1  channel-C beat valid
c_ready  in  1  channel-C beat accepted
c_opcode  out  3  7 = ReleaseData, 5 = ProbeAckData
c_param  out  3  req_param
c_size  out  3  log2(blockBytes) = 6
c_source  out  sourceBits  req_source
c_address  out  paddrBits  {tag, idx, 6'b0}, constant over the burst
c_data  out  rowBits  beat data
release_ack  in  1  ReleaseAck pulse for this unit's source
busy  out  1  state != IDLE
busy_idx  out  idxBits  latched idx (set-conflict check by MSHRs)
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: state IDLE, all counters 0, buffer empty; all valid/pulse outputs 0, req_ready 1, busy 0, registered fields 0.
- IDLE: req_valid && req_ready latches all req fields -> READ next cycle.
- READ: two counters rd_cnt (reads issued, 0..4) and tx_cnt (beats accepted, 0..4); 2-entry beat FIFO.
  - data_req_valid = (rd_cnt < 4) && (fifo_count + inflight < 2); data_req_addr = {idx, rd_cnt[1:0]}.
  - Accepted read sets inflight for one cycle; next cycle data_resp is pushed into the FIFO unconditionally (space is reserved at issue).
  - c_valid = FIFO non-empty; c_data = FIFO head. Beat pop on c_valid && c_ready; tx_cnt++.
  - Same-cycle push and pop allowed; count unchanged.
  - c_valid held with stable payload until c_ready (no retraction).
  - tx_cnt reaches 4: voluntary -> WAIT_ACK; else done=1 and -> IDLE.
- WAIT_ACK: wait for release_ack; then done=1 and -> IDLE. A release_ack in any other state is ignored.
- Throughput: with c_ready and data_req_ready held high, one beat per cycle. First c_valid appears 2 cycles after request acceptance; the last beat is accepted 5 cycles after acceptance.
- data_req_ready low stalls issue only; buffered beats keep draining.
- busy_idx is valid while busy; a new req is never accepted the same cycle done pulses.
- Reset asserted mid-burst: immediate abort to IDLE; in-flight data_resp is discarded.

Decomposition:
- Shared package (dcache params): blockOffBits, idxBits, tagBits, rowBits, refillCycles, TileLink C opcode constants (ProbeAckData=5, ReleaseData=7), and a wb_req struct typedef.
- One sub-module: wb_beat_fifo (2-entry, rowBits wide, push/pop/count).

Test Plan:
- Voluntary, ready always high: tag=0xABCDE, idx=5, way_en=0x04 -> reads addr 20..23 on consecutive cycles. Beats 0..3 carry matching data, opcode 7, address 0xABCDE140, size 6. busy stays 1 until release_ack; done pulses the cycle after it.
- Probe writeback (voluntary=0): opcode 5, param echoed; done pulses the cycle after the 4th beat, with no wait for release_ack.
- c_ready low for 5 cycles after beat 0: at most 2 rows buffered, no further data_req_valid, beat 1 payload held stable; order preserved after release.
- data_req_ready toggling 1/0 each cycle: 4 reads issued, beats in order, no duplicated or skipped row.
- release_ack during READ is ignored; unit still waits in WAIT_ACK for a later release_ack.
- Reset asserted after beat 1: next cycle all outputs at reset values and req_ready=1; a fresh request completes a full 4-beat burst correctly.

Source files
------------

// File: rtl/dcache_wb_unit_pkg.sv
// rtl/dcache_wb_unit_pkg.sv - shared dcache parameters, TileLink C opcodes and writeback request type
package dcache_wb_unit_pkg;

  localparam int PADDR_BITS     = 32;
  localparam int BLOCK_BYTES    = 64;
  localparam int BLOCK_OFF_BITS = $clog2(BLOCK_BYTES);
  localparam int N_SETS         = 64;
  localparam int IDX_BITS       = $clog2(N_SETS);
  localparam int N_WAYS         = 8;
  localparam int ROW_BITS       = 128;
  localparam int TAG_BITS       = PADDR_BITS - 12;
  localparam int SOURCE_BITS    = 3;
  localparam int REFILL_CYCLES  = BLOCK_BYTES * 8 / ROW_BITS;

  localparam logic [2:0] OPC_PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] OPC_RELEASE_DATA   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_READ     = 2'd1,
    S_WAIT_ACK = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [IDX_BITS-1:0]    idx;
    logic [N_WAYS-1:0]      way_en;
    logic                   voluntary;
    logic [2:0]             param;
    logic [SOURCE_BITS-1:0] source;
  } wb_req_t;

  // Block-aligned physical address of the victim line.
  function automatic logic [PADDR_BITS-1:0] block_addr(
    input logic [TAG_BITS-1:0] tag,
    input logic [IDX_BITS-1:0] idx
  );
    return {tag, idx, {BLOCK_OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_beat_fifo.sv
// rtl/wb_beat_fifo.sv - 2-entry first-word-fall-through beat buffer between data array and channel C
module wb_beat_fifo
  import dcache_wb_unit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                push_i,
  input  logic [ROW_BITS-1:0] push_data_i,
  input  logic                pop_i,
  output logic                valid_o,
  output logic [ROW_BITS-1:0] head_o,
  output logic [1:0]          count_o
);

  logic [ROW_BITS-1:0] mem_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic                empty;
  logic                bypass;
  logic                do_write;
  logic                do_read;

  // An arriving row is visible at the head the cycle it lands, so an empty
  // buffer adds no latency; if it is consumed that same cycle it is never stored.
  assign empty    = (count_q == 2'd0);
  assign bypass   = empty && push_i && pop_i;
  assign do_write = push_i && !bypass;
  assign do_read  = pop_i && !empty;
  assign valid_o  = !empty || push_i;
  assign head_o   = (empty && push_i) ? push_data_i : mem_q[rd_ptr_q];
  assign count_o  = count_q;

  // Occupancy after this cycle's store/consume.
  always_comb begin
    count_d = count_q;
    if (do_write && !do_read) count_d = count_q + 2'd1;
    if (!do_write && do_read) count_d = count_q - 2'd1;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_write) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_read) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dcache_wb_unit.sv
// rtl/dcache_wb_unit.sv - L1 dcache writeback engine streaming dirty blocks as TileLink channel-C bursts
module dcache_wb_unit
  import dcache_wb_unit_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [TAG_BITS-1:0]    req_tag,
  input  logic [IDX_BITS-1:0]    req_idx,
  input  logic [N_WAYS-1:0]      req_way_en,
  input  logic                   req_voluntary,
  input  logic [2:0]             req_param,
  input  logic [SOURCE_BITS-1:0] req_source,
  output logic                   data_req_valid,
  input  logic                   data_req_ready,
  output logic [IDX_BITS+1:0]    data_req_addr,
  output logic [N_WAYS-1:0]      data_req_way_en,
  input  logic [ROW_BITS-1:0]    data_resp,
  output logic                   c_valid,
  input  logic                   c_ready,
  output logic [2:0]             c_opcode,
  output logic [2:0]             c_param,
  output logic [2:0]             c_size,
  output logic [SOURCE_BITS-1:0] c_source,
  output logic [PADDR_BITS-1:0]  c_address,
  output logic [ROW_BITS-1:0]    c_data,
  input  logic                   release_ack,
  output logic                   busy,
  output logic [IDX_BITS-1:0]    busy_idx,
  output logic                   done
);

  localparam logic [2:0] BEATS = 3'(REFILL_CYCLES);

  wb_state_e   state_q, state_d;
  wb_req_t     req_q, req_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [2:0]  rd_cnt_q, rd_cnt_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic        inflight_q, inflight_d;
  logic        ack_q, ack_d;

  logic        rd_fire;
  logic        beat_pop;
  logic [1:0]  fifo_count;
  logic        fifo_valid;
  logic [ROW_BITS-1:0] fifo_head;

  // A read is only issued when a buffer slot is guaranteed for its response,
  // because data_resp cannot be back-pressured.
  assign data_req_valid  = (state_q == S_READ) && (rd_cnt_q < BEATS) &&
                           (({1'b0, fifo_count} + {2'b0, inflight_q}) < 3'd2);
  assign data_req_addr   = {req_q.idx, rd_cnt_q[1:0]};
  assign data_req_way_en = req_q.way_en;
  assign rd_fire         = data_req_valid && data_req_ready;

  assign c_valid   = fifo_valid;
  assign c_data    = fifo_head;
  assign beat_pop  = c_valid && c_ready;
  assign c_opcode  = opcode_q;
  assign c_param   = req_q.param;
  assign c_size    = 3'(BLOCK_OFF_BITS);
  assign c_source  = req_q.source;
  assign c_address = block_addr(req_q.tag, req_q.idx);

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign busy_idx  = req_q.idx;

  wb_beat_fifo u_beat_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (data_resp),
    .pop_i       (beat_pop),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Next-state, request capture, read/beat counters and the done pulse.
  // done is raised while still busy so a new request cannot overlap it.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    opcode_d   = opcode_q;
    rd_cnt_d   = rd_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    inflight_d = rd_fire;
    ack_d      = ack_q;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_READ;
          req_d    = '{tag: req_tag, idx: req_idx, way_en: req_way_en,
                       voluntary: req_voluntary, param: req_param, source: req_source};
          opcode_d = req_voluntary ? OPC_RELEASE_DATA : OPC_PROBE_ACK_DATA;
          rd_cnt_d = 3'd0;
          tx_cnt_d = 3'd0;
          ack_d    = 1'b0;
        end
      end
      S_READ: begin
        if (rd_fire)  rd_cnt_d = rd_cnt_q + 3'd1;
        if (beat_pop) tx_cnt_d = tx_cnt_q + 3'd1;
        if (tx_cnt_q == BEATS) begin
          if (req_q.voluntary) begin
            state_d = S_WAIT_ACK;
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_ACK: begin
        if (ack_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (release_ack) begin
          ack_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched request fields; reset aborts any burst in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      opcode_q   <= 3'd0;
      rd_cnt_q   <= 3'd0;
      tx_cnt_q   <= 3'd0;
      inflight_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      opcode_q   <= opcode_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      inflight_q <= inflight_d;
      ack_q      <= ack_d;
    end
  end

endmodule
